// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and FSM encoding for the data-memory responder
// Contents: funct3 access-width codes, responder FSM state type.
package dmem_responder_pkg;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_mem_lane_fmt.sv
// rtl/dmem_responder_mem_lane_fmt.sv - byte-lane steering, load extension and access checking
// Purpose: combinational formatter between LSB-aligned request data and a 32-bit memory word.
// Ports:
//   addr_lo   in   2   low byte-address bits
//   width     in   3   funct3 access width
//   we        in   1   1 = store
//   wdata     in   32  store data, LSB-aligned
//   rword     in   32  memory word at the request index
//   be        out  4   store byte enables (meaningful only when err=0)
//   wdata_sh  out  32  store data moved onto its byte lanes
//   rdata_ext out  32  extracted and sign/zero-extended load data
//   err       out  1   misaligned access or illegal width for this direction
module mem_lane_fmt
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  width,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte     = rword[{addr_lo, 3'b000} +: 8];
    rhalf     = rword[{addr_lo[1], 4'b0000} +: 16];
    be        = 4'b0000;
    wdata_sh  = wdata << {addr_lo, 3'b000};
    rdata_ext = 32'd0;
    err       = 1'b0;
    case (width)
      W_B: begin
        be        = 4'b0001 << addr_lo;
        rdata_ext = {{24{rbyte[7]}}, rbyte};
      end
      W_BU: begin
        // unsigned widths only exist for loads
        err       = we;
        rdata_ext = {24'd0, rbyte};
      end
      W_H: begin
        err       = addr_lo[0];
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext = {{16{rhalf[15]}}, rhalf};
      end
      W_HU: begin
        err       = we | addr_lo[0];
        rdata_ext = {16'd0, rhalf};
      end
      W_W: begin
        err       = (addr_lo != 2'b00);
        be        = 4'b1111;
        rdata_ext = rword;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with fixed response latency
// Purpose: one request at a time; stores commit at accept, loads are read at accept and
// returned LATENCY cycles later, held until consumed.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_addr[ADDR_W], req_width[3] byte address, funct3 width
//   req_we, req_wdata[32]          store flag and LSB-aligned store data
//   resp_valid/resp_ready          response handshake (valid only in RESP)
//   resp_rdata[32], resp_err       extended load data (0 for stores/errors), error flag
//   stall_mem                      hazard-unit stall request
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_width,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall_mem
);

  localparam int         DEPTH  = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [ADDR_W-3:0]   idx;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wdata_sh;
  logic [31:0]         rdata_ext;
  logic                fmt_err;
  logic                accept;

  // index ignores addr[1:0]; upper bits wrap naturally, so there is no range error
  assign idx    = req_addr[ADDR_W-1:2];
  assign rword  = mem[idx];
  assign accept = req_valid & req_ready;

  mem_lane_fmt u_fmt (
    .addr_lo   (req_addr[1:0]),
    .width     (req_width),
    .we        (req_we),
    .wdata     (req_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .err       (fmt_err)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall_mem  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        stall_mem = req_valid;
        if (req_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall_mem = 1'b1;
        if (cnt_q == 4'd0) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        stall_mem  = ~resp_ready;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The formatted result is captured at accept instead of the raw request fields, and
  // only moved onto resp_* when RESP is entered so the outputs hold their previous
  // values through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q   <= LAT_M1;
            err_q   <= fmt_err;
            rdata_q <= (req_we | fmt_err) ? 32'd0 : rdata_ext;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            resp_rdata <= rdata_q;
            resp_err   <= err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is never cleared; reset only blocks a write in the accept cycle.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && !fmt_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int ADDR_W  = 15;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_width;
  logic              req_we;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall_mem;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_width  (req_width),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall_mem  (stall_mem)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Issue one request, wait for its response with resp_ready high, return the response.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [2:0] w,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_width  = w;
    req_wdata  = wd;
    resp_ready = 1'b1;
    #1;
    check("stall_on_req_valid", {31'd0, stall_mem}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    k = 1;
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k - 1), 32'(LATENCY));
    rd = resp_rdata;
    er = resp_err;
  endtask

  // Reference model: byte-addressed memory plus the access rules in plain arithmetic.
  logic [7:0] mm [int];

  task automatic model(input logic we, input logic [ADDR_W-1:0] addr, input logic [2:0] w,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    er = 1'b0;
    n  = 0;
    rd = 32'd0;
    case (w)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd4: begin n = 1; er = we; end
      3'd5: begin n = 2; er = we; end
      default: er = 1'b1;
    endcase
    if (n == 2 && (int'(addr) % 2) != 0) er = 1'b1;
    if (n == 4 && (int'(addr) % 4) != 0) er = 1'b1;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[int'(addr) + i]) << (8 * i));
        if (w == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (w == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  typedef struct {
    string             name;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        w;
    logic [31:0]       wd;
    logic [31:0]       exp_rd;
    logic              exp_err;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] rd, rd0;
    logic        er, mer;
    logic [31:0] mrd;
    logic        rwe;
    logic [ADDR_W-1:0] raddr;
    logic [2:0]  rw;
    logic [31:0] rwd;
    int          k;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_width = 3'd0;
    req_we = 1'b0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready",  {31'd0, req_ready},  32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_rdata", resp_rdata,          32'd0);
    check("reset_resp_err",   {31'd0, resp_err},   32'd0);
    check("reset_stall_mem",  {31'd0, stall_mem},  32'd0);

    vt.push_back('{"sw_deadbeef",   1'b1, 15'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0});
    vt.push_back('{"lw_10",         1'b0, 15'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
    vt.push_back('{"sb_80_13",      1'b1, 15'h13, 3'b000, 32'h80,       32'h0,        1'b0});
    vt.push_back('{"lb_13",         1'b0, 15'h13, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0});
    vt.push_back('{"lbu_13",        1'b0, 15'h13, 3'b100, 32'h0,        32'h00000080, 1'b0});
    vt.push_back('{"lw_after_sb",   1'b0, 15'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0});
    vt.push_back('{"sh_misaligned", 1'b1, 15'h11, 3'b001, 32'h1234,     32'h0,        1'b1});
    vt.push_back('{"lw_unchanged",  1'b0, 15'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0});
    vt.push_back('{"lh_12",         1'b0, 15'h12, 3'b001, 32'h0,        32'hFFFF80AD, 1'b0});
    vt.push_back('{"lhu_12",        1'b0, 15'h12, 3'b101, 32'h0,        32'h000080AD, 1'b0});
    vt.push_back('{"lbu_11",        1'b0, 15'h11, 3'b100, 32'h0,        32'h000000BE, 1'b0});
    vt.push_back('{"lw_misaligned", 1'b0, 15'h12, 3'b010, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"sbu_illegal",   1'b1, 15'h10, 3'b100, 32'hFF,       32'h0,        1'b1});
    vt.push_back('{"w110_illegal",  1'b0, 15'h10, 3'b110, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"lw_final_10",   1'b0, 15'h10, 3'b010, 32'h0,        32'h80ADBEEF, 1'b0});

    foreach (vt[i]) begin
      do_req(vt[i].we, vt[i].addr, vt[i].w, vt[i].wd, rd, er);
      check({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
      check({vt[i].name, "_err"}, {31'd0, er}, {31'd0, vt[i].exp_err});
    end

    // Back-pressure: response held stable while resp_ready is low
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h10; req_width = 3'b010;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 50) begin @(negedge clk); k++; end
    check("bp_resp_valid_seen", {31'd0, resp_valid}, 32'd1);
    rd0 = resp_rdata;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata",      resp_rdata,          rd0);
      check("bp_req_ready",  {31'd0, req_ready},  32'd0);
      check("bp_stall_mem",  {31'd0, stall_mem},  32'd1);
    end
    check("bp_rdata_value", rd0, 32'h80ADBEEF);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_consumed_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_consumed_ready", {31'd0, req_ready},  32'd1);
    check("bp_consumed_stall", {31'd0, stall_mem},  32'd0);

    // Reset one cycle after accepting a store: store remains committed
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h20; req_width = 3'b010;
    req_wdata = 32'h55AA55AA;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_wait_req_ready",  {31'd0, req_ready},  32'd1);
    do_req(1'b0, 15'h20, 3'b010, 32'h0, rd, er);
    check("rst_wait_lw_20", rd, 32'h55AA55AA);

    // Reset in the accept cycle: store is dropped
    do_req(1'b1, 15'h24, 3'b010, 32'h00000077, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h24; req_width = 3'b010;
    req_wdata = 32'h1; rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    check("rst_accept_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_accept_resp_valid", {31'd0, resp_valid}, 32'd0);
    do_req(1'b0, 15'h24, 3'b010, 32'h0, rd, er);
    check("rst_accept_lw_24", rd, 32'h00000077);
    do_req(1'b0, 15'h24, 3'b011, 32'h0, rd, er);
    check("w011_rdata", rd, 32'h0);
    check("w011_err",   {31'd0, er}, 32'd1);

    // Randomised traffic against the byte-level model
    for (int a = 0; a < 32; a += 4) begin
      rwd = $urandom;
      raddr = 15'(32'h200 + a);
      model(1'b1, raddr, 3'b010, rwd, mrd, mer);
      do_req(1'b1, raddr, 3'b010, rwd, rd, er);
      check("rand_init_err", {31'd0, er}, {31'd0, mer});
    end
    for (int t = 0; t < 200; t++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = 15'(32'h200 + $urandom_range(0, 31));
      rw    = 3'($urandom_range(0, 7));
      rwd   = $urandom;
      model(rwe, raddr, rw, rwd, mrd, mer);
      do_req(rwe, raddr, rw, rwd, rd, er);
      check("rand_rdata", rd, mrd);
      check("rand_err", {31'd0, er}, {31'd0, mer});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
